// File: rtl/mult_cu.sv
// mult_cu: Moore control unit for the shift-add multiplier datapath.
// Sequences load/add/shift through ldA/ldB/ldP, ctrlA/ctrlB and Psel.
module mult_cu #(
    parameter int NBITS = 4,
    parameter bit USE_Z = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic b0,
    input  logic z,
    output logic ldA,
    output logic ldB,
    output logic ctrlA,
    output logic ctrlB,
    output logic Psel,
    output logic ldP,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(NBITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          last;
    logic          stop;

    assign last = (cnt == CMAX);
    assign stop = last | (USE_Z & z);

    // State register; reset from any state returns to idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Iteration counter: cleared on load, bumped once per shift, saturating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == S_LOAD) begin
            cnt <= '0;
        end else if (state == S_SHIFT && !last) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Next-state selection; unused encodings fall back to idle.
    always_comb begin
        state_nx = S_IDLE;
        unique case (state)
            S_IDLE: begin
                state_nx = start ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (stop) begin
                    state_nx = S_DONE;
                end else if (b0) begin
                    state_nx = S_ADD;
                end else begin
                    state_nx = S_SHIFT;
                end
            end
            S_ADD: begin
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                state_nx = S_CHECK;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Output decode from the state register alone.
    always_comb begin
        ldA   = 1'b0;
        ldB   = 1'b0;
        ctrlA = 1'b0;
        ctrlB = 1'b0;
        Psel  = 1'b0;
        ldP   = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                ldA  = 1'b1;
                ldB  = 1'b1;
                ldP  = 1'b1;
                busy = 1'b1;
            end
            S_CHECK: begin
                busy = 1'b1;
            end
            S_ADD: begin
                ldP  = 1'b1;
                Psel = 1'b1;
                busy = 1'b1;
            end
            S_SHIFT: begin
                ldA   = 1'b1;
                ldB   = 1'b1;
                ctrlA = 1'b1;
                ctrlB = 1'b1;
                busy  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_cu.sv
// tb_mult_cu: drives two control units (counter-only and z-terminated)
// against behavioural shift-add datapaths and a latency/product model.
module tb_mult_cu;

    logic       clk;
    logic       reset;
    logic [1:0] start;
    logic [1:0] b0;
    logic [1:0] z;
    logic [1:0] ldA, ldB, ctrlA, ctrlB, Psel, ldP, busy, done;

    logic [7:0] ra [2];
    logic [7:0] rp [2];
    logic [3:0] rb [2];
    logic [3:0] ain [2];
    logic [3:0] bin [2];
    logic [1:0] zforce;

    int checks;
    int failures;

    mult_cu #(.NBITS(4), .USE_Z(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .b0(b0[0]), .z(z[0]),
        .ldA(ldA[0]), .ldB(ldB[0]), .ctrlA(ctrlA[0]), .ctrlB(ctrlB[0]),
        .Psel(Psel[0]), .ldP(ldP[0]), .busy(busy[0]), .done(done[0])
    );

    mult_cu #(.NBITS(4), .USE_Z(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .b0(b0[1]), .z(z[1]),
        .ldA(ldA[1]), .ldB(ldB[1]), .ctrlA(ctrlA[1]), .ctrlB(ctrlB[1]),
        .Psel(Psel[1]), .ldP(ldP[1]), .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign b0 = {rb[1][0], rb[0][0]};
    assign z  = {zforce[1] | (rb[1] == 4'h0), zforce[0] | (rb[0] == 4'h0)};

    // Behavioural datapath: A shifts left, B shifts right, P accumulates.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ldA[i]) ra[i] <= ctrlA[i] ? (ra[i] << 1) : {4'h0, ain[i]};
            if (ldB[i]) rb[i] <= ctrlB[i] ? (rb[i] >> 1) : bin[i];
            if (ldP[i]) rp[i] <= Psel[i] ? (rp[i] + ra[i]) : 8'h00;
        end
    end

    function automatic logic [7:0] outs(input int i);
        return {ldA[i], ldB[i], ldP[i], ctrlA[i], ctrlB[i],
                Psel[i], busy[i], done[i]};
    endfunction

    function automatic int pop(input logic [3:0] b);
        int n = 0;
        for (int k = 0; k < 4; k++) n += int'(b[k]);
        return n;
    endfunction

    function automatic int msb1(input logic [3:0] b);
        int n = 0;
        for (int k = 0; k < 4; k++) if (b[k]) n = k + 1;
        return n;
    endfunction

    // Iterations run to NBITS, or to the last 1 bit when z ends the loop.
    function automatic int ref_lat(input logic [3:0] b, input bit usez);
        int iters = usez ? msb1(b) : 4;
        return 2 + 2 * iters + pop(b);
    endfunction

    localparam logic [7:0] V_LOAD = 8'b1110_0010;

    task automatic run_one(input int i, input logic [3:0] a, input logic [3:0] b,
                           output int lat, output int adds,
                           output logic [7:0] prod, output logic [7:0] loadv);
        ain[i] = a;
        bin[i] = b;
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        loadv = outs(i);
        lat = -1;
        adds = 0;
        prod = 8'hxx;
        for (int e = 1; e <= 60 && lat < 0; e++) begin
            @(posedge clk);
            #1;
            if (ldP[i] && Psel[i]) adds++;
            if (done[i]) begin
                lat = e;
                prod = rp[i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (outs(i) !== 8'h00) begin
                failures++;
                $display("FAIL reset_outs[%0d] got=%b want=%b", i, outs(i), 8'h00);
            end
        end
    endtask

    task automatic test_vectors();
        logic [3:0] va [3] = '{4'd3, 4'd9, 4'hF};
        logic [3:0] vb [3] = '{4'b0101, 4'd0, 4'hF};
        int lat, adds;
        logic [7:0] prod, lv;
        for (int t = 0; t < 3; t++) begin
            run_one(0, va[t], vb[t], lat, adds, prod, lv);
            checks++;
            if (lv !== V_LOAD) begin
                failures++;
                $display("FAIL vec%0d_load got=%b want=%b", t, lv, V_LOAD);
            end
            checks++;
            if (lat != ref_lat(vb[t], 1'b0)) begin
                failures++;
                $display("FAIL vec%0d_lat got=%0d want=%0d", t, lat, ref_lat(vb[t], 1'b0));
            end
            checks++;
            if (adds != pop(vb[t])) begin
                failures++;
                $display("FAIL vec%0d_adds got=%0d want=%0d", t, adds, pop(vb[t]));
            end
            checks++;
            if (prod !== 8'(va[t] * vb[t])) begin
                failures++;
                $display("FAIL vec%0d_prod got=%h want=%h", t, prod, 8'(va[t] * vb[t]));
            end
        end
    endtask

    task automatic test_random();
        int lat, adds;
        logic [7:0] prod, lv;
        logic [3:0] a, b;
        for (int t = 0; t < 24; t++) begin
            int i = t % 2;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            run_one(i, a, b, lat, adds, prod, lv);
            checks++;
            if (lat != ref_lat(b, i == 1)) begin
                failures++;
                $display("FAIL rnd_lat dut%0d a=%h b=%h got=%0d want=%0d",
                         i, a, b, lat, ref_lat(b, i == 1));
            end
            checks++;
            if (prod !== 8'(a * b) || adds != pop(b)) begin
                failures++;
                $display("FAIL rnd_prod dut%0d a=%h b=%h got=%h/%0d want=%h/%0d",
                         i, a, b, prod, adds, 8'(a * b), pop(b));
            end
        end
    endtask

    task automatic test_reset_midrun();
        int dones = 0;
        int lat, adds;
        logic [7:0] prod, lv;
        ain[0] = 4'hF;
        bin[0] = 4'hF;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outs(0) !== 8'h00) begin
            failures++;
            $display("FAIL midreset_outs got=%b want=%b", outs(0), 8'h00);
        end
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done[0] || busy[0]) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL midreset_quiet got=%0d want=0", dones);
        end
        run_one(0, 4'd7, 4'd6, lat, adds, prod, lv);
        checks++;
        if (prod !== 8'd42 || lat != ref_lat(4'd6, 1'b0)) begin
            failures++;
            $display("FAIL midreset_rerun got=%h/%0d want=%h/%0d",
                     prod, lat, 8'd42, ref_lat(4'd6, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        int per = ref_lat(4'd5, 1'b0) + 2;
        int exp_loads = 39 / per + 1;
        int loads = 0;
        int gap_err = 0;
        int prod_err = 0;
        bit prev_done = 1'b0;
        bit want_load = 1'b0;
        bit isload;
        ain[0] = 4'd3;
        bin[0] = 4'd5;
        @(negedge clk);
        start[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            isload = (outs(0) == V_LOAD);
            if (isload) loads++;
            if (want_load) begin
                if (!isload) gap_err++;
                want_load = 1'b0;
            end
            if (prev_done) begin
                if (busy[0]) gap_err++;
                want_load = 1'b1;
            end
            if (done[0] && rp[0] !== 8'd15) prod_err++;
            prev_done = done[0];
        end
        @(negedge clk);
        start[0] = 1'b0;
        for (int c = 0; c < 40 && busy[0]; c++) begin
            @(posedge clk);
            #1;
            if (done[0] && rp[0] !== 8'd15) prod_err++;
        end
        checks++;
        if (loads != exp_loads) begin
            failures++;
            $display("FAIL b2b_loads got=%0d want=%0d", loads, exp_loads);
        end
        checks++;
        if (gap_err != 0 || prod_err != 0) begin
            failures++;
            $display("FAIL b2b_gap got=%0d/%0d want=0/0", gap_err, prod_err);
        end
        checks++;
        if (busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got=%b want=0", busy[0]);
        end
    endtask

    task automatic test_start_while_busy();
        int loads = 0;
        int extra = 0;
        int lat = -1;
        ain[0] = 4'hF;
        bin[0] = 4'hF;
        @(negedge clk);
        start[0] = 1'b1;
        for (int e = 0; e <= 60 && lat < 0; e++) begin
            @(posedge clk);
            #1;
            if (outs(0) == V_LOAD) loads++;
            if (done[0]) begin
                lat = e;
            end else begin
                @(negedge clk);
                start[0] = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        start[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (busy[0]) extra++;
        end
        checks++;
        if (loads != 1 || extra != 0) begin
            failures++;
            $display("FAIL busy_start got=%0d/%0d want=1/0", loads, extra);
        end
        checks++;
        if (lat != ref_lat(4'hF, 1'b0) || rp[0] !== 8'hE1) begin
            failures++;
            $display("FAIL busy_start_lat got=%0d/%h want=%0d/%h",
                     lat, rp[0], ref_lat(4'hF, 1'b0), 8'hE1);
        end
    endtask

    task automatic test_early_z();
        int lat, adds;
        logic [7:0] prod, lv;
        run_one(1, 4'd9, 4'd0, lat, adds, prod, lv);
        checks++;
        if (lat != 2 || prod !== 8'h00) begin
            failures++;
            $display("FAIL z_zero got=%0d/%h want=2/00", lat, prod);
        end
        zforce[1] = 1'b1;
        run_one(1, 4'd3, 4'd5, lat, adds, prod, lv);
        zforce[1] = 1'b0;
        checks++;
        if (lat != 2 || prod !== 8'h00 || adds != 0) begin
            failures++;
            $display("FAIL z_forced got=%0d/%h/%0d want=2/00/0", lat, prod, adds);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        start = 2'b00;
        zforce = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ra[i] = 8'h00;
            rp[i] = 8'h00;
            rb[i] = 4'h0;
            ain[i] = 4'h0;
            bin[i] = 4'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_vectors();
        test_random();
        test_reset_midrun();
        test_back_to_back();
        test_start_while_busy();
        test_early_z();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
